radix2_fft_ctrl: RTL

- Sequencing controller for the radix-2 FFT data path; sits directly upstream of it.
- Drives the bank addresses, the twiddle index, the source-select, BRAM write-enable, butterfly clock-enable and FFT-ready controls.
- Runs three phases: load N samples as N/2 pairs, run LOG2N in-place butterfly stages, then stream N/2 result pairs out under backpressure.
- Inter-stage data permutation (constant-geometry wiring) lives in the data path; this block generates linear pair indices only.

---
 rtl/radix2_fft_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/radix2_fft_ctrl.sv
// Sequencing controller for an in-place radix-2 FFT data path: loads N/2 sample
// pairs, runs LOG2N butterfly stages with a BF_LAT-deep write-back pipe, then unloads.
module radix2_fft_ctrl #(
  parameter int N      = 1024,
  parameter int LOG2N  = 10,
  parameter int ADDR_W = 9,
  parameter int BF_LAT = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [ADDR_W-1:0] tw_addr_o,
  output logic              src_sel_o,
  output logic              bram_we_o,
  output logic              bf_ce_o,
  output logic              fft_ready_o,
  output logic [3:0]        stage_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, UNLOAD} state_t;

  localparam logic [ADDR_W-1:0] P_LAST = ADDR_W'(N / 2 - 1);
  localparam logic [3:0]        S_LAST = 4'(LOG2N - 1);
  localparam logic [3:0]        D_LAST = 4'(BF_LAT - 1);

  state_t            state;
  logic [ADDR_W-1:0] p;
  logic [3:0]        s;
  logic [3:0]        d;
  logic [BF_LAT-1:0] pipe_v;
  logic [ADDR_W-1:0] pipe_a [BF_LAT];
  logic              issue;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;

  assign issue    = (state == COMPUTE);
  assign wb_valid = pipe_v[BF_LAT-1];
  assign wb_addr  = pipe_a[BF_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      p     <= '0;
      s     <= '0;
      d     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state <= LOAD;
            p     <= '0;
            s     <= '0;
          end
        end
        LOAD: begin
          if (in_valid_i) begin
            if (p == P_LAST) begin
              state <= COMPUTE;
              p     <= '0;
            end else begin
              p <= p + 1'b1;
            end
          end
        end
        COMPUTE: begin
          d <= '0;
          if (p == P_LAST) state <= DRAIN;
          else             p     <= p + 1'b1;
        end
        DRAIN: begin
          // Hold here until the final write of this stage has left the pipe.
          if (d == D_LAST) begin
            d <= '0;
            p <= '0;
            if (s == S_LAST) begin
              state <= UNLOAD;
            end else begin
              s     <= s + 4'd1;
              state <= COMPUTE;
            end
          end else begin
            d <= d + 4'd1;
          end
        end
        UNLOAD: begin
          if (out_ready_i) begin
            if (p == P_LAST) begin
              state <= IDLE;
              p     <= '0;
              s     <= '0;
            end else begin
              p <= p + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
    end else begin
      for (int i = BF_LAT - 1; i > 0; i--) pipe_v[i] <= pipe_v[i-1];
      pipe_v[0] <= issue;
    end
  end

  // NOTE: the address stages carry no reset; they are only observed when their
  // valid bit (which is reset) is set, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    for (int i = BF_LAT - 1; i > 0; i--) pipe_a[i] <= pipe_a[i-1];
    pipe_a[0] <= p;
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    rd_addr_o   = '0;
    wr_addr_o   = '0;
    tw_addr_o   = '0;
    src_sel_o   = 1'b0;
    bram_we_o   = 1'b0;
    bf_ce_o     = 1'b0;
    fft_ready_o = 1'b0;
    done_o      = 1'b0;
    stage_o     = s;
    busy_o      = (state != IDLE);
    case (state)
      LOAD: begin
        in_ready_o = 1'b1;
        bram_we_o  = in_valid_i && !rst;
        wr_addr_o  = p;
      end
      COMPUTE, DRAIN: begin
        bf_ce_o   = 1'b1;
        src_sel_o = 1'b1;
        bram_we_o = wb_valid && !rst;
        wr_addr_o = wb_valid ? wb_addr : '0;
        if (state == COMPUTE) begin
          rd_addr_o = p;
          tw_addr_o = (p >> s) << s;
        end
      end
      UNLOAD: begin
        fft_ready_o = 1'b1;
        out_valid_o = 1'b1;
        rd_addr_o   = p;
        done_o      = out_ready_i && (p == P_LAST);
      end
      default: ;
    endcase
  end

endmodule
